// File: rtl/mem_wb_arbiter.sv
// Two-master Wishbone arbiter for the shared SRAM slave: round-robin grant held
// for the owner's whole cyc tenure, with a watchdog that aborts stalled strobes.
module mem_wb_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  output logic [31:0]   m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  output logic [31:0]   m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    grant_o,
  output logic          timeout_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, GNT, ERR} state_t;

  state_t              state;
  logic                owner;
  logic                last_owner;
  logic [CW-1:0]       wd_cnt;

  logic [1:0]          cyc, stb, we, req;
  logic [1:0][3:0]     sel;
  logic [1:0][AW-1:0]  adr;
  logic [1:0][31:0]    dat;
  logic [1:0]          ack_v, err_v;
  logic                pick, stall, wd_hit;

  assign cyc = {m1_cyc_i, m0_cyc_i};
  assign stb = {m1_stb_i, m0_stb_i};
  assign we  = {m1_we_i,  m0_we_i};
  assign sel = {m1_sel_i, m0_sel_i};
  assign adr = {m1_adr_i, m0_adr_i};
  assign dat = {m1_dat_i, m0_dat_i};
  assign req = cyc & stb;

  // On a tie the master that did not own the bus last wins.
  assign pick   = (req == 2'b11) ? ~last_owner : req[1];
  assign stall  = (state == GNT) && stb[owner] && !s_ack_i;
  assign wd_hit = (TIMEOUT > 0) && stall && (wd_cnt == WD_LAST);

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (state == GNT) begin
      s_cyc_o = cyc[owner];
      s_stb_o = stb[owner];
      s_we_o  = we[owner];
      s_sel_o = sel[owner];
      s_adr_o = adr[owner];
      s_dat_o = dat[owner];
    end
  end

  // Acks only reach the owner while granted, so a late ack in ERR is dropped.
  for (genvar i = 0; i < 2; i++) begin : g_rsp
    assign ack_v[i] = (state == GNT) && (owner == i[0]) && s_ack_i;
    assign err_v[i] = timeout_o && (owner == i[0]);
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = ack_v[0];
  assign m1_ack_o = ack_v[1];
  assign m0_err_o = err_v[0];
  assign m1_err_o = err_v[1];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      grant_o    <= 2'b00;
      wd_cnt     <= '0;
      timeout_o  <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (|req) begin
            owner   <= pick;
            grant_o <= pick ? 2'b10 : 2'b01;
            state   <= GNT;
          end
        end
        GNT: begin
          if (!cyc[owner]) begin
            last_owner <= owner;
            grant_o    <= 2'b00;
            wd_cnt     <= '0;
            state      <= IDLE;
          end else if (wd_hit) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b1;
            state     <= ERR;
          end else if (stall && (TIMEOUT > 0)) begin
            wd_cnt <= wd_cnt + 1'b1;
          end else begin
            wd_cnt <= '0;
          end
        end
        ERR: begin
          wd_cnt <= '0;
          if (!cyc[owner]) begin
            last_owner <= owner;
            grant_o    <= 2'b00;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_arbiter.sv
// Bench for mem_wb_arbiter: SRAM slave model plus a reference memory/arbitration
// model; directed scenarios followed by randomized two-master traffic.
module tb_mem_wb_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  mcyc, mstb, mwe;
  logic [3:0]  msel [2];
  logic [31:0] madr [2];
  logic [31:0] mwd  [2];
  wire  [31:0] mrd0, mrd1;
  wire  [1:0]  mack, merr;
  wire         s_cyc, s_stb, s_we;
  wire  [3:0]  s_sel;
  wire  [31:0] s_adr, s_wd;
  logic [31:0] s_rd;
  logic        s_ack;
  wire  [1:0]  grant;
  wire         tmo;

  mem_wb_arbiter #(.AW(32), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_sel_i(msel[0]),
    .m0_adr_i(madr[0]), .m0_dat_i(mwd[0]), .m0_dat_o(mrd0), .m0_ack_o(mack[0]), .m0_err_o(merr[0]),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_sel_i(msel[1]),
    .m1_adr_i(madr[1]), .m1_dat_i(mwd[1]), .m1_dat_o(mrd1), .m1_ack_o(mack[1]), .m1_err_o(merr[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
    .s_dat_o(s_wd), .s_dat_i(s_rd), .s_ack_i(s_ack), .grant_o(grant), .timeout_o(tmo)
  );

  // SRAM slave: write ack one cycle after stb, read ack two cycles after stb.
  logic [31:0] smem [1024];
  logic        rd_wait;
  logic        tie_low = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack   <= 1'b0;
      rd_wait <= 1'b0;
      s_rd    <= '0;
    end else begin
      s_ack <= 1'b0;
      if (s_cyc && s_stb && !s_ack && !tie_low) begin
        if (s_we) begin
          for (int b = 0; b < 4; b++)
            if (s_sel[b]) smem[s_adr[11:2]][8*b +: 8] <= s_wd[8*b +: 8];
          s_ack <= 1'b1;
        end else if (!rd_wait) begin
          rd_wait <= 1'b1;
        end else begin
          rd_wait <= 1'b0;
          s_rd    <= smem[s_adr[11:2]];
          s_ack   <= 1'b1;
        end
      end else begin
        rd_wait <= 1'b0;
      end
    end
  end

  // Reference model: expected memory contents and round-robin history.
  logic [31:0] emem [1024];
  bit          last_model;
  int          errs = 0;
  int          checks = 0;

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    emem[a[11:2]] = (emem[a[11:2]] & ~mask) | (d & mask);
  endfunction

  task automatic raise(input int m, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = w; madr[m] = a; mwd[m] = d; msel[m] = s;
  endtask

  task automatic drop(input int m);
    mcyc[m] = 1'b0; mstb[m] = 1'b0;
    last_model = (m == 1);
  endtask

  // Issue one access and wait (bounded) for its ack; lat=0 means no ack came.
  task automatic do_op(input int m, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output int lat, output bit spur);
    raise(m, w, a, d, s);
    lat = 0; spur = 0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mack[(m == 0) ? 1 : 0] || merr[(m == 0) ? 1 : 0]) spur = 1;
      if (mack[m]) begin
        rd = (m == 0) ? mrd0 : mrd1;
        lat = i;
        break;
      end
    end
    mstb[m] = 1'b0;
    if (w && lat != 0) model_write(a, d, s);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mcyc = '0; mstb = '0; mwe = '0;
    for (int i = 0; i < 2; i++) begin msel[i] = '0; madr[i] = '0; mwd[i] = '0; end
    tie_low = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_model = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mcyc = '0; mstb = '0;
    #1;
    checks++; if (grant !== 2'b00) begin errs++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_wd} !== '0) begin errs++;
      $display("FAIL reset_slave: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want all 0", s_cyc, s_stb, s_we, s_sel, s_adr, s_wd); end
    checks++; if ({mack, merr, tmo} !== 5'b0) begin errs++;
      $display("FAIL reset_rsp: ack=%b err=%b tmo=%b want 0", mack, merr, tmo); end
    do_reset();
  endtask

  task automatic test_single_read();
    logic [31:0] rd; int lat; bit spur;
    raise(0, 0, 32'h10, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errs++; $display("FAIL single_grant: got %b want 01", grant); end
    checks++; if (s_stb !== 1'b1 || s_adr !== 32'h10) begin errs++;
      $display("FAIL single_slave: stb=%b adr=%h want 1 00000010", s_stb, s_adr); end
    do_op(0, 0, 32'h10, 32'h0, 4'hF, rd, lat, spur);
    checks++; if (lat !== 2) begin errs++; $display("FAIL single_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL single_data: got %h want deadbeef", rd); end
    checks++; if (spur) begin errs++; $display("FAIL single_m1_ack: got 1 want 0"); end
    drop(0);
    @(negedge clk);
  endtask

  task automatic test_tie();
    logic [31:0] rd; int lat; bit spur;
    do_reset();
    raise(0, 0, 32'h10, 0, 4'hF);
    raise(1, 0, 32'h14, 0, 4'hF);
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errs++; $display("FAIL tie_first: got %b want 01", grant); end
    do_op(0, 0, 32'h10, 0, 4'hF, rd, lat, spur);
    drop(0);
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errs++; $display("FAIL tie_idle_gap: got %b want 00", grant); end
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errs++; $display("FAIL tie_second: got %b want 10", grant); end
    do_op(1, 0, 32'h14, 0, 4'hF, rd, lat, spur);
    checks++; if (lat == 0 || spur) begin errs++; $display("FAIL tie_m1_ack: lat=%0d spur=%0d want ack, no spur", lat, spur); end
    drop(1);
    @(negedge clk);
    raise(0, 0, 32'h10, 0, 4'hF);
    raise(1, 0, 32'h14, 0, 4'hF);
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errs++; $display("FAIL tie_alternate: got %b want 01", grant); end
    do_op(0, 0, 32'h10, 0, 4'hF, rd, lat, spur);
    drop(0);
    do_op(1, 0, 32'h14, 0, 4'hF, rd, lat, spur);
    drop(1);
    @(negedge clk);
  endtask

  task automatic test_block();
    logic [31:0] rd; int lat; bit spur; int acks; bit held;
    acks = 0; held = 1;
    raise(0, 1, 32'h800, 32'h0, 4'hF);
    @(negedge clk);
    raise(1, 0, 32'h804, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      do_op(0, 1, 32'h800 + 4 * k, $urandom, 4'hF, rd, lat, spur);
      if (lat != 0 && !spur) acks++;
      if (grant !== 2'b01) held = 0;
    end
    checks++; if (acks !== 4) begin errs++; $display("FAIL block_acks: got %0d want 4", acks); end
    checks++; if (!held) begin errs++; $display("FAIL block_lock: grant left 01 during block"); end
    drop(0);
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errs++; $display("FAIL block_gap: got %b want 00", grant); end
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errs++; $display("FAIL block_m1_grant: got %b want 10", grant); end
    do_op(1, 0, 32'h804, 0, 4'hF, rd, lat, spur);
    checks++; if (rd !== emem[32'h804 >> 2] || lat == 0) begin errs++;
      $display("FAIL block_readback: got %h want %h", rd, emem[32'h804 >> 2]); end
    drop(1);
    @(negedge clk);
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lat; bit spur;
    raise(1, 1, 32'h20, 32'hAABBCCDD, 4'b0100);
    @(negedge clk);
    checks++; if (s_sel !== 4'b0100 || grant !== 2'b10) begin errs++;
      $display("FAIL lanes_sel: sel=%b grant=%b want 0100 10", s_sel, grant); end
    do_op(1, 1, 32'h20, 32'hAABBCCDD, 4'b0100, rd, lat, spur);
    drop(1);
    @(negedge clk);
    do_op(1, 0, 32'h20, 0, 4'hF, rd, lat, spur);
    checks++; if (rd !== 32'h00BB0000) begin errs++; $display("FAIL lanes_readback: got %h want 00bb0000", rd); end
    drop(1);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd; int lat; bit spur;
    bit w [2]; logic [31:0] a [2]; logic [31:0] d [2]; logic [3:0] s [2];
    int pat, f, o;
    for (int it = 0; it < 24; it++) begin
      pat = $urandom_range(1, 3);
      for (int m = 0; m < 2; m++) begin
        w[m] = $urandom_range(0, 1);
        a[m] = 32'h100 + 4 * $urandom_range(0, 7);
        d[m] = $urandom;
        s[m] = 4'($urandom_range(1, 15));
        if (pat[m]) raise(m, w[m], a[m], d[m], s[m]);
      end
      f = (pat == 3) ? (last_model ? 0 : 1) : ((pat == 2) ? 1 : 0);
      o = 1 - f;
      @(negedge clk);
      checks++; if (grant !== ((f == 1) ? 2'b10 : 2'b01)) begin errs++;
        $display("FAIL rand_grant it=%0d: got %b want m%0d", it, grant, f); end
      exp_rd = emem[a[f][11:2]];
      do_op(f, w[f], a[f], d[f], s[f], rd, lat, spur);
      checks++; if (lat == 0 || spur || (!w[f] && rd !== exp_rd)) begin errs++;
        $display("FAIL rand_op it=%0d m%0d: lat=%0d spur=%0d rd=%h want %h", it, f, lat, spur, rd, exp_rd); end
      drop(f);
      if (pat == 3) begin
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errs++; $display("FAIL rand_gap it=%0d: got %b want 00", it, grant); end
        exp_rd = emem[a[o][11:2]];
        do_op(o, w[o], a[o], d[o], s[o], rd, lat, spur);
        checks++; if (lat == 0 || spur || (!w[o] && rd !== exp_rd)) begin errs++;
          $display("FAIL rand_op2 it=%0d m%0d: lat=%0d spur=%0d rd=%h want %h", it, o, lat, spur, rd, exp_rd); end
        drop(o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_watchdog();
    logic [31:0] rd; int lat; bit spur; int n; bit sawack;
    n = 0; sawack = 0;
    tie_low = 1'b1;
    raise(0, 0, 32'h30, 0, 4'hF);
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errs++; $display("FAIL wd_grant: got %b want 01", grant); end
    raise(1, 0, 32'h10, 0, 4'hF);
    while (s_stb && n < 40) begin
      n++;
      if (mack[0] || merr[0]) sawack = 1;
      @(negedge clk);
    end
    checks++; if (n !== TO || sawack) begin errs++; $display("FAIL wd_cycles: got %0d early_rsp=%0d want %0d 0", n, sawack, TO); end
    checks++; if (merr !== 2'b01 || tmo !== 1'b1 || s_cyc !== 1'b0) begin errs++;
      $display("FAIL wd_abort: err=%b tmo=%b s_cyc=%b want 01 1 0", merr, tmo, s_cyc); end
    @(negedge clk);
    checks++; if (merr !== 2'b00 || tmo !== 1'b0) begin errs++;
      $display("FAIL wd_pulse: err=%b tmo=%b want 00 0", merr, tmo); end
    tie_low = 1'b0;
    drop(0);
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errs++; $display("FAIL wd_idle: got %b want 00", grant); end
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errs++; $display("FAIL wd_next: got %b want 10", grant); end
    do_op(1, 0, 32'h10, 0, 4'hF, rd, lat, spur);
    checks++; if (rd !== emem[4] || lat == 0) begin errs++; $display("FAIL wd_m1_read: got %h want %h", rd, emem[4]); end
    drop(1);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] rd; int lat; bit spur; bit bad;
    bad = 0;
    raise(0, 0, 32'h10, 0, 4'hF);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || s_adr !== 32'h0 || mack !== 2'b00) begin errs++;
      $display("FAIL areset_now: grant=%b cyc=%b stb=%b adr=%h ack=%b want all 0", grant, s_cyc, s_stb, s_adr, mack); end
    repeat (3) begin
      @(negedge clk);
      if (mack !== 2'b00 || merr !== 2'b00) bad = 1;
    end
    checks++; if (bad) begin errs++; $display("FAIL areset_no_rsp: ack/err seen during reset, want none"); end
    raise(1, 0, 32'h14, 0, 4'hF);
    rst_n = 1'b1;
    last_model = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errs++; $display("FAIL areset_tie: got %b want 01", grant); end
    do_op(0, 0, 32'h10, 0, 4'hF, rd, lat, spur);
    checks++; if (rd !== emem[4] || lat == 0) begin errs++; $display("FAIL areset_read: got %h want %h", rd, emem[4]); end
    drop(0);
    do_op(1, 0, 32'h14, 0, 4'hF, rd, lat, spur);
    drop(1);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin smem[i] = '0; emem[i] = '0; end
    smem[4] = 32'hDEADBEEF;
    emem[4] = 32'hDEADBEEF;
    test_reset();
    test_single_read();
    test_tie();
    test_block();
    test_byte_lanes();
    test_random();
    test_watchdog();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errs + 1);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/mem_wb_arbiter.md
Name: mem_wb_arbiter

Overview:
- Two-master Wishbone arbiter that shares the SoC SRAM slave (mem_wb) between the CPU (master 0) and the DMA/housekeeping engine (master 1).
- Grants the bus round-robin and locks it for a master's whole cyc tenure.
- Multiplexes the granted master onto the slave and routes ack back to that master only.
- A bus watchdog aborts a stalled tenure with an err pulse so a hung master cannot starve the other.

Parameters:
- AW, 32, address width of all address ports.
- TIMEOUT, 255, max cycles with s_stb_o high and no s_ack_i before abort; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls.
- m0_sel_i  in  4  master 0 byte selects.
- m0_adr_i  in  AW  master 0 address.
- m0_dat_i  in  32  master 0 write data.
- m0_dat_o  out  32  master 0 read data.
- m0_ack_o, m0_err_o  out  1 each  master 0 responses.
- m1_*  same set as m0_*  master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls.
- s_sel_o  out  4  slave byte selects.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  32  slave write data.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge.
- grant_o  out  2  one-hot current owner; 00 when idle.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (wb_rst_ni low, asynchronous): state=IDLE, grant_o=00, last_owner=1 (so master 0 wins the first tie), watchdog count=0, timeout_o=0.
- Response outputs under reset: all ack/err outputs are 0.
- Slave-facing outputs under reset: s_cyc_o=s_stb_o=s_we_o=0, s_sel_o=0, s_adr_o=0, s_dat_o=0.
- Request definition: mX requests when mX_cyc_i & mX_stb_i.
- IDLE state:
  - If exactly one master requests, register its grant; next state GNT.
  - If both request, grant the master != last_owner.
  - If none requests, stay in IDLE.
  - Arbitration latency is one cycle: the request is visible at the slave one cycle after it first appears.
- GNT state:
  - Slave outputs combinationally follow the owner's cyc/stb/we/sel/adr/dat.
  - Owner's mX_dat_o = s_dat_i and mX_ack_o = s_ack_i.
  - Non-owner ack/err = 0; both mX_dat_o always = s_dat_i.
  - Owner keeps the bus while its cyc_i stays high, including back-to-back stb strobes (block cycles).
  - When owner cyc_i = 0: last_owner <= owner, go to IDLE, grant_o <= 00.
  - There is always at least one IDLE cycle between tenures, even if the other master is waiting.
- Outputs outside GNT: slave outputs all 0 (so the slave's SRAM enable stays low).
- Watchdog (TIMEOUT > 0):
  - Counter increments each GNT cycle with s_stb_o=1 and s_ack_i=0.
  - Counter clears on s_ack_i, when s_stb_o=0, or on leaving GNT.
  - When count reaches TIMEOUT with no ack: go to ERR.
- ERR state:
  - Slave outputs forced 0.
  - Owner's mX_err_o=1 and timeout_o=1 for exactly the first ERR cycle, then 0.
  - Remain in ERR until owner cyc_i=0; then last_owner <= owner and go to IDLE.
  - A late s_ack_i in ERR is discarded (never routed to any master).
- Simultaneous events:
  - ack and owner cyc drop in the same cycle: the ack is delivered, then the tenure is released.
  - Watchdog expiry and ack in the same cycle: the ack wins and the counter clears.
- Reset mid-tenure: immediate return to reset values; no ack/err is generated for the aborted access.
- Counter width: $clog2(TIMEOUT+1); it never wraps.
- The arbiter adds no pipeline register on the data/ack paths. Slave timing is preserved: write ack 1 cycle after stb, read ack 2 cycles after stb.

Test Plan:
- Single master read: m0 reads 0x0000_0010 (word 4, preloaded 0xDEADBEEF), m1 idle.
  - -> grant_o=01 one cycle after request; m0_ack_o 2 cycles after s_stb_o; m0_dat_o=0xDEADBEEF; m1_ack_o stays 0.
- Tie round-robin: both request from reset.
  - -> m0 served first. m0 drops cyc -> one IDLE cycle (grant_o=00) -> grant_o=10.
  - Both request again -> m0 granted (alternation).
- Block cycle lock: m0 holds cyc and issues 4 writes to 0x800..0x80C while m1 requests.
  - -> four m0 acks, grant_o stays 01 throughout; m1 is granted only after m0 cyc drops.
  - m1 reads back 0x804 -> value written by m0.
- Byte lanes: m1 writes 0xAABBCCDD with sel=0100 to word 0x20 (previously 0).
  - -> s_sel_o=0100; read back = 0x00BB0000.
- Watchdog: TIMEOUT=8, slave ack tied low, m0 strobes.
  - -> in cycle 8 of the strobe, m0_err_o and timeout_o pulse once and s_cyc_o drops.
  - m0 drops cyc -> IDLE; pending m1 is granted next.
- Async reset: assert wb_rst_ni low mid-read, between stb and ack.
  - -> all outputs 0 immediately and no ack. After release, both requesting -> m0 granted first.
